inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction fetch stage directly upstream of the CPU core. It drives the core's `inst` input and holds it stable for the whole RS/ID/RG/EX/MM/WB/BL instruction cycle.
- Owns the program counter and talks to an instruction ROM/RAM over a req/ack handshake.
- Keeps a one-entry prefetch buffer, so the next sequential instruction is normally ready when the core finishes BL.
- Accepts a branch redirect from the core; the redirect flushes the prefetch buffer.

Parameters:
- WIDTH, 16: instruction width; must equal `WIDTH.
- ADDR_WIDTH, 8: instruction address width; the PC wraps modulo 2^ADDR_WIDTH.
- RESET_PC, 0: first fetch address after reset.

Ports:
- clk  in  1  system clock, rising edge.
- res  in  1  asynchronous, active-low reset.
- next  in  1  one-cycle pulse from the core in state BL; consumes the current instruction.
- br_en  in  1  qualifies `next` as a taken branch.
- br_addr  in  ADDR_WIDTH  branch target, sampled when next&br_en.
- inst  out  WIDTH  instruction to the core; all-zero (NOP) while inst_valid=0.
- inst_valid  out  1  inst holds a fetched instruction.
- pc  out  ADDR_WIDTH  address of the instruction currently on inst.
- mem_req  out  1  fetch request to instruction memory.
- mem_addr  out  ADDR_WIDTH  fetch address; stable while mem_req=1 until mem_ack.
- mem_rdata  in  WIDTH  read data, valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle completion strobe; never asserted without mem_req.

Behaviour:
- Reset is asynchronous, active-low, and may arrive at any time.
  - Output values under reset: inst=0, inst_valid=0, pc=RESET_PC, mem_req=0, mem_addr=RESET_PC.
  - Internal values under reset: buf_valid=0, fetch_addr=RESET_PC, state=FS_REQ.
  - Reset mid-handshake drops the request; any later ack is ignored until mem_req is reasserted.
- FSM states and per-state behaviour:
  - FS_REQ: mem_req=1, mem_addr=fetch_addr.
  - FS_FULL: mem_req=0. inst is valid and the buffer holds the next instruction.
- Ack handling, when mem_ack=1 in FS_REQ and no branch is taken in the same cycle:
  - If inst_valid=0: inst<=mem_rdata, pc<=fetch_addr, inst_valid<=1, fetch_addr<=fetch_addr+1. Stay in FS_REQ (prefetch).
  - If inst_valid=1: buf<=mem_rdata, buf_valid<=1, fetch_addr<=fetch_addr+1. Go to FS_FULL.
- Sequential consume, when next=1 and br_en=0:
  - If buf_valid: inst<=buf, pc<=pc+1, buf_valid<=0. Go to FS_REQ.
  - Else, with mem_ack in the same cycle: ack data goes straight to inst and pc<=fetch_addr; inst_valid stays 1.
  - Else: inst_valid<=0 and inst reads 0; stay in FS_REQ.
- Branch, when next=1 and br_en=1:
  - Effects: buf_valid<=0, inst_valid<=0, fetch_addr<=br_addr. Go to FS_REQ.
  - A mem_ack in the same cycle is discarded.
  - If a request is outstanding, mem_addr switches to br_addr the next cycle. The memory must tolerate an address change on a request it has not acked; the fetch unit treats the next ack as belonging to br_addr.
- `next` while inst_valid=0 is illegal and is ignored (no state change). The assertion checker flags it.
- Latency:
  - With a memory that acks one cycle after req, the first instruction is valid 2 cycles after reset release.
  - The sequential refill after next is zero cycles when the buffer is full.
  - The branch penalty is request cycle plus memory latency.
- Wrap-around: fetch_addr and pc increment modulo 2^ADDR_WIDTH, so max → 0 with no flag.
- inst and inst_valid are registered outputs. mem_req and mem_addr are registered and decoded from state.

Decomposition:
- Additions to define.v:
  - FS_REQ/FS_FULL encodings and FS_STATE_WIDTH.
  - `NOP (all-zero instruction).
  - `ADDR_WIDTH default.
- Natural sub-module: fetch_buf, the one-entry data+valid holding register with load, flush and pop.
- PC/FSM logic stays in inst_fetch.

Test Plan:
- Reset release, memory acks 1 cycle after req, mem[0]=16'h1234:
  - 2 cycles after release: inst=16'h1234, inst_valid=1, pc=0.
  - mem_addr then advances to 1.
- Prefetch then consume, mem[1]=16'h5678:
  - After ack of address 1: FS_FULL, mem_req=0.
  - next pulse → inst=16'h5678 and pc=1 the following cycle; mem_req=1 with mem_addr=2.
- Branch: next=1, br_en=1, br_addr=8'h40 while FS_FULL:
  - Buffer flushed, inst_valid=0, inst=0.
  - mem_addr=8'h40; after ack, inst=mem[0x40] and pc=8'h40.
- Branch coincident with mem_ack of address 5:
  - Data for 5 is discarded.
  - The next fetch is br_addr; pc never shows 5.
- Wrap: RESET_PC=8'hFF:
  - Fetch 0xFF, then prefetch 0x00.
  - After next: pc=0x00 with inst=mem[0].
- Async reset asserted mid-request (mem_req=1, no ack):
  - Outputs go to reset values immediately.
  - A late mem_ack during reset is ignored.
  - After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared encodings and defaults for the instruction fetch stage
package inst_fetch_pkg;

    localparam int FS_STATE_WIDTH = 1;

    // FS_REQ: a fetch request is (or is about to be) outstanding.
    // FS_FULL: inst is valid and the prefetch buffer holds the next instruction.
    typedef enum logic [FS_STATE_WIDTH-1:0] {
        FS_REQ  = 1'b0,
        FS_FULL = 1'b1
    } fs_state_e;

    localparam int DEF_WIDTH      = 16;
    localparam int DEF_ADDR_WIDTH = 8;

    // All-zero instruction presented to the core while nothing valid is held
    localparam logic [DEF_WIDTH-1:0] NOP = '0;

endpackage

// File: rtl/inst_fetch_buf.sv
// rtl/inst_fetch_buf.sv - one-entry prefetch holding register with load, flush and pop
module inst_fetch_buf #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             res,
    input  logic             load,
    input  logic             flush,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid
);

    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    // Flush wins over load so a branch can never leave a stale prefetch behind
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            data_q  <= din;
            valid_q <= 1'b1;
        end else if (pop) begin
            valid_q <= 1'b0;
        end
    end

    assign dout  = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: PC, memory handshake, prefetch and branch redirect
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                    WIDTH      = DEF_WIDTH,
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  next,
    input  logic                  br_en,
    input  logic [ADDR_WIDTH-1:0] br_addr,
    output logic [WIDTH-1:0]      inst,
    output logic                  inst_valid,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0]      mem_rdata,
    input  logic                  mem_ack
);

    fs_state_e             state_q, state_d;
    logic [WIDTH-1:0]      inst_q, inst_d;
    logic                  inst_valid_q, inst_valid_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
    logic                  mem_req_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;

    logic                  take, branch, ack;
    logic                  buf_load, buf_flush, buf_pop, buf_valid;
    logic [WIDTH-1:0]      buf_data;

    // next is only honoured while an instruction is held; an ack only counts
    // against a request that was actually presented (drops acks after reset)
    assign take      = next && inst_valid_q;
    assign branch    = take && br_en;
    assign ack       = mem_ack && mem_req_q && (state_q == FS_REQ);
    assign buf_flush = branch;
    assign buf_pop   = take && !br_en && buf_valid;
    assign buf_load  = !take && ack && inst_valid_q;

    inst_fetch_buf #(.WIDTH(WIDTH)) u_buf (
        .clk   (clk),
        .res   (res),
        .load  (buf_load),
        .flush (buf_flush),
        .pop   (buf_pop),
        .din   (mem_rdata),
        .dout  (buf_data),
        .valid (buf_valid)
    );

    // Next-state decode: branch beats sequential consume beats a plain ack
    always_comb begin
        state_d      = state_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        if (branch) begin
            inst_d       = WIDTH'(NOP);
            inst_valid_d = 1'b0;
            fetch_addr_d = br_addr;
            state_d      = FS_REQ;
        end else if (take) begin
            if (buf_valid) begin
                inst_d  = buf_data;
                pc_d    = pc_q + ADDR_WIDTH'(1);
                state_d = FS_REQ;
            end else if (ack) begin
                inst_d       = mem_rdata;
                pc_d         = fetch_addr_q;
                fetch_addr_d = fetch_addr_q + ADDR_WIDTH'(1);
            end else begin
                inst_d       = WIDTH'(NOP);
                inst_valid_d = 1'b0;
            end
        end else if (ack) begin
            fetch_addr_d = fetch_addr_q + ADDR_WIDTH'(1);
            if (!inst_valid_q) begin
                inst_d       = mem_rdata;
                pc_d         = fetch_addr_q;
                inst_valid_d = 1'b1;
            end else begin
                state_d = FS_FULL;
            end
        end
    end

    // State and registered outputs; the memory port is decoded from the next state
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q      <= FS_REQ;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            pc_q         <= RESET_PC;
            fetch_addr_q <= RESET_PC;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= RESET_PC;
        end else begin
            state_q      <= state_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            mem_req_q    <= (state_d == FS_REQ);
            mem_addr_q   <= fetch_addr_d;
        end
    end

    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign pc         = pc_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed vector bench for inst_fetch
module tb_inst_fetch;

    typedef struct packed {
        logic        next;
        logic        br_en;
        logic [7:0]  br_addr;
        logic        ack_en;
        logic [15:0] inst;
        logic        valid;
        logic [7:0]  pc;
        logic        pc_dc;
        logic        req;
        logic [7:0]  addr;
    } vec_t;

    logic        clk = 1'b0;
    logic        res;
    logic        next;
    logic        br_en;
    logic [7:0]  br_addr;
    logic [15:0] inst;
    logic        inst_valid;
    logic [7:0]  pc;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        ack_en;
    logic        man_ack;

    int tests = 0;
    int fails = 0;
    vec_t vecs[24];

    always #5 clk = ~clk;

    function automatic logic [15:0] memval(input logic [7:0] a);
        if (a == 8'h00) return 16'h1234;
        if (a == 8'h01) return 16'h5678;
        return {~a, a};
    endfunction

    assign mem_rdata = memval(mem_addr);
    assign mem_ack   = (mem_req & ack_en) | man_ack;

    inst_fetch #(
        .WIDTH      (16),
        .ADDR_WIDTH (8),
        .RESET_PC   (8'h00)
    ) u_dut (
        .clk        (clk),
        .res        (res),
        .next       (next),
        .br_en      (br_en),
        .br_addr    (br_addr),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc         (pc),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [15:0] e_inst, input logic e_valid,
                              input logic [7:0] e_pc, input logic pc_dc, input logic e_req,
                              input logic [7:0] e_addr);
        check({tag, "_inst"}, 32'(inst), 32'(e_inst));
        check({tag, "_valid"}, 32'(inst_valid), 32'(e_valid));
        if (!pc_dc) check({tag, "_pc"}, 32'(pc), 32'(e_pc));
        check({tag, "_req"}, 32'(mem_req), 32'(e_req));
        check({tag, "_addr"}, 32'(mem_addr), 32'(e_addr));
    endtask

    function automatic vec_t mk(input logic n, input logic b, input logic [7:0] ba, input logic ae,
                                input logic [15:0] ei, input logic ev, input logic [7:0] ep,
                                input logic dc, input logic er, input logic [7:0] ea);
        vec_t v;
        v = '{next: n, br_en: b, br_addr: ba, ack_en: ae, inst: ei, valid: ev,
              pc: ep, pc_dc: dc, req: er, addr: ea};
        return v;
    endfunction

    initial begin
        //            nx br  br_addr ae  inst             v  pc     dc req addr
        vecs[0]  = mk(0, 0, 8'h00, 1, 16'h0000,         0, 8'h00, 0, 1, 8'h00);
        vecs[1]  = mk(0, 0, 8'h00, 1, 16'h1234,         1, 8'h00, 0, 1, 8'h01);
        vecs[2]  = mk(0, 0, 8'h00, 1, 16'h1234,         1, 8'h00, 0, 0, 8'h02);
        vecs[3]  = mk(1, 0, 8'h00, 1, 16'h5678,         1, 8'h01, 0, 1, 8'h02);
        vecs[4]  = mk(0, 0, 8'h00, 0, 16'h5678,         1, 8'h01, 0, 1, 8'h02);
        vecs[5]  = mk(0, 0, 8'h00, 1, 16'h5678,         1, 8'h01, 0, 0, 8'h03);
        vecs[6]  = mk(1, 1, 8'h40, 1, 16'h0000,         0, 8'h00, 1, 1, 8'h40);
        vecs[7]  = mk(0, 0, 8'h00, 1, memval(8'h40),    1, 8'h40, 0, 1, 8'h41);
        vecs[8]  = mk(0, 0, 8'h00, 1, memval(8'h40),    1, 8'h40, 0, 0, 8'h42);
        vecs[9]  = mk(1, 0, 8'h00, 1, memval(8'h41),    1, 8'h41, 0, 1, 8'h42);
        vecs[10] = mk(0, 0, 8'h00, 1, memval(8'h41),    1, 8'h41, 0, 0, 8'h43);
        vecs[11] = mk(1, 0, 8'h00, 0, memval(8'h42),    1, 8'h42, 0, 1, 8'h43);
        vecs[12] = mk(1, 1, 8'h04, 0, 16'h0000,         0, 8'h00, 1, 1, 8'h04);
        vecs[13] = mk(0, 0, 8'h00, 1, memval(8'h04),    1, 8'h04, 0, 1, 8'h05);
        vecs[14] = mk(1, 1, 8'h80, 1, 16'h0000,         0, 8'h00, 1, 1, 8'h80);
        vecs[15] = mk(0, 0, 8'h00, 1, memval(8'h80),    1, 8'h80, 0, 1, 8'h81);
        vecs[16] = mk(1, 0, 8'h00, 0, 16'h0000,         0, 8'h00, 1, 1, 8'h81);
        vecs[17] = mk(1, 0, 8'h00, 0, 16'h0000,         0, 8'h00, 1, 1, 8'h81);
        vecs[18] = mk(0, 0, 8'h00, 1, memval(8'h81),    1, 8'h81, 0, 1, 8'h82);
        vecs[19] = mk(1, 0, 8'h00, 1, memval(8'h82),    1, 8'h82, 0, 1, 8'h83);
        vecs[20] = mk(1, 1, 8'hFF, 0, 16'h0000,         0, 8'h00, 1, 1, 8'hFF);
        vecs[21] = mk(0, 0, 8'h00, 1, memval(8'hFF),    1, 8'hFF, 0, 1, 8'h00);
        vecs[22] = mk(0, 0, 8'h00, 1, memval(8'hFF),    1, 8'hFF, 0, 0, 8'h01);
        vecs[23] = mk(1, 0, 8'h00, 0, 16'h1234,         1, 8'h00, 0, 1, 8'h01);

        res = 1'b0; next = 1'b0; br_en = 1'b0; br_addr = '0; ack_en = 1'b1; man_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_outs("reset", 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        res = 1'b1;

        for (int i = 0; i < 24; i++) begin
            next    = vecs[i].next;
            br_en   = vecs[i].br_en;
            br_addr = vecs[i].br_addr;
            ack_en  = vecs[i].ack_en;
            @(posedge clk);
            @(negedge clk);
            check_outs($sformatf("v%0d", i), vecs[i].inst, vecs[i].valid, vecs[i].pc,
                       vecs[i].pc_dc, vecs[i].req, vecs[i].addr);
        end
        next = 1'b0; br_en = 1'b0; ack_en = 1'b0;

        // Asynchronous reset mid-request, with a stray ack during and after reset
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_req", 32'(mem_req), 32'd1);
        #2 res = 1'b0;
        #1 check_outs("rst_async", 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        man_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_outs("rst_late_ack", 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        res = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_outs("rst_rel1", 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
        man_ack = 1'b0;
        ack_en  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_outs("rst_rel2", 16'h1234, 1'b1, 8'h00, 1'b0, 1'b1, 8'h01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
